// File: rtl/tri_inv_pkg.sv
// Shared constants, state encoding and index helpers for the triangular inverse stage.
package tri_inv_pkg;
    localparam int N            = 8;
    localparam int W            = 32;
    localparam int FRAC         = 29;
    localparam int RECIP_CYCLES = 34;

    localparam logic [31:0] RECIP_MIN = 32'h0800_0000;
    localparam logic [31:0] SAT       = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, RECIP, MAC, SCALE, WRITE, DONE} state_t;

    // Element (r,c) of a packed 8x8 matrix lives at word r*8+c.
    function automatic logic [5:0] idx(input logic [2:0] r, input logic [2:0] c);
        return {r, c};
    endfunction

    function automatic logic signed [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/recip_div_q29.sv
// Restoring divider producing floor(2^58 / d) in 32 iterations; saturates when d <= 0.25.
module recip_div_q29
    import tri_inv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         done,
    output logic         err
);
    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic [W-1:0] dreg;
    logic [4:0]   iter;
    logic         running;
    logic         sat;
    logic [W:0]   shifted;

    assign shifted = {rem, 1'b0};
    assign q       = sat ? SAT : quo;
    assign err     = sat;

    // The dividend 2^58 has high word 2^26 and an all-zero low word, so only zeros shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            dreg    <= '0;
            iter    <= '0;
            running <= 1'b0;
            sat     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dreg    <= d;
                rem     <= 32'h0400_0000;
                quo     <= '0;
                iter    <= '0;
                running <= 1'b1;
                sat     <= ($signed(d) <= $signed(RECIP_MIN));
            end else if (running) begin
                if (shifted >= {1'b0, dreg}) begin
                    rem <= W'(shifted - {1'b0, dreg});
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= shifted[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
                iter <= iter + 1'b1;
                if (iter == 5'd31) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/tri_inverse_stage.sv
// Forward-substitution inverse of an 8x8 complex lower-triangular factor, X = L^-1,
// emitted together with X^H in the packed format of the downstream multiply stage.
module tri_inverse_stage
    import tri_inv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N*N*W-1:0]   L_real_in,
    input  logic [N*N*W-1:0]   L_imag_in,
    output logic [N*N*W-1:0]   L_inv_real_out,
    output logic [N*N*W-1:0]   L_inv_imag_out,
    output logic [N*N*W-1:0]   L_inv_tran_real_out,
    output logic [N*N*W-1:0]   L_inv_tran_imag_out,
    output logic               out_valid,
    output logic               busy,
    output logic               div_err
);
    state_t state;

    logic [W-1:0] l_re [N*N];
    logic [W-1:0] l_im [N*N];
    logic [W-1:0] x_re [N*N];
    logic [W-1:0] x_im [N*N];
    logic [W-1:0] rec  [N];

    logic [2:0] row_i, col_j, k_idx, span;
    logic [3:0] step;
    logic [5:0] rcnt;

    logic signed [63:0] ar, ai, br, bi;
    logic signed [63:0] prod_re, prod_im;
    logic signed [63:0] p_re, p_im, acc_re, acc_im;
    logic [W-1:0]       s_re, s_im;

    logic         div_start, div_done, div_err_w;
    logic [W-1:0] div_q;

    assign busy      = (state != IDLE);
    assign span      = row_i - col_j;
    assign k_idx     = col_j + step[2:0];
    assign div_start = (state == RECIP) && (rcnt == '0);

    // One complex product L(i,k) * X(k,j) per MAC cycle; the diagonal of X is real.
    assign ar      = sext(l_re[idx(row_i, k_idx)]);
    assign ai      = sext(l_im[idx(row_i, k_idx)]);
    assign br      = sext(x_re[idx(k_idx, col_j)]);
    assign bi      = sext(x_im[idx(k_idx, col_j)]);
    assign prod_re = ar * br - ai * bi;
    assign prod_im = ar * bi + ai * br;

    recip_div_q29 u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .d     (l_re[idx(row_i, row_i)]),
        .q     (div_q),
        .done  (div_done),
        .err   (div_err_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_i     <= '0;
            col_j     <= '0;
            step      <= '0;
            rcnt      <= '0;
            p_re      <= '0;
            p_im      <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            s_re      <= '0;
            s_im      <= '0;
            out_valid <= 1'b0;
            div_err   <= 1'b0;
            for (int e = 0; e < N*N; e++) begin
                l_re[6'(e)] <= '0;
                l_im[6'(e)] <= '0;
                x_re[6'(e)] <= '0;
                x_im[6'(e)] <= '0;
            end
            for (int r = 0; r < N; r++) rec[3'(r)] <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: if (in_valid) begin
                    for (int e = 0; e < N*N; e++) begin
                        l_re[6'(e)] <= L_real_in[e*W +: W];
                        l_im[6'(e)] <= L_imag_in[e*W +: W];
                    end
                    div_err <= 1'b0;
                    acc_re  <= '0;
                    acc_im  <= '0;
                    p_re    <= '0;
                    p_im    <= '0;
                    rcnt    <= '0;
                    row_i   <= '0;
                    state   <= RECIP;
                end
                RECIP: begin
                    rcnt <= rcnt + 1'b1;
                    if (div_done && rcnt == 6'(RECIP_CYCLES - 1)) begin
                        rec[row_i]                <= div_q;
                        x_re[idx(row_i, row_i)]   <= div_q;
                        x_im[idx(row_i, row_i)]   <= '0;
                        if (div_err_w) div_err    <= 1'b1;
                        rcnt                      <= '0;
                        if (row_i == 3'(N - 1)) begin
                            row_i <= 3'd1;
                            col_j <= '0;
                            step  <= '0;
                            state <= MAC;
                        end else begin
                            row_i <= row_i + 1'b1;
                        end
                    end
                end
                // Products are registered one cycle ahead of accumulation; the last step drains.
                MAC: begin
                    if (step < {1'b0, span}) begin
                        p_re <= prod_re;
                        p_im <= prod_im;
                    end
                    if (step != '0) begin
                        acc_re <= acc_re + (p_re >>> FRAC);
                        acc_im <= acc_im + (p_im >>> FRAC);
                    end
                    if (step == {1'b0, span}) state <= SCALE;
                    step <= step + 1'b1;
                end
                SCALE: begin
                    s_re  <= W'(-((sext(acc_re[W-1:0]) * sext(rec[row_i])) >>> FRAC));
                    s_im  <= W'(-((sext(acc_im[W-1:0]) * sext(rec[row_i])) >>> FRAC));
                    state <= WRITE;
                end
                WRITE: begin
                    x_re[idx(row_i, col_j)] <= s_re;
                    x_im[idx(row_i, col_j)] <= s_im;
                    acc_re <= '0;
                    acc_im <= '0;
                    step   <= '0;
                    if (row_i == 3'(N - 1)) begin
                        if (col_j == 3'(N - 2)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            col_j <= col_j + 1'b1;
                            row_i <= col_j + 3'd2;
                            state <= MAC;
                        end
                    end else begin
                        row_i <= row_i + 1'b1;
                        state <= MAC;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign L_inv_real_out[(r*N+c)*W +: W]      = x_re[r*N+c];
            assign L_inv_imag_out[(r*N+c)*W +: W]      = x_im[r*N+c];
            assign L_inv_tran_real_out[(c*N+r)*W +: W] = x_re[r*N+c];
            assign L_inv_tran_imag_out[(c*N+r)*W +: W] = -x_im[r*N+c];
        end
    end
endmodule

// File: tb/tb_tri_inverse_stage.sv
// Directed bench for tri_inverse_stage: a forward-substitution model plus cycle-level
// latency tracking, and literal expectations for the hand-worked matrices.
module tb_tri_inverse_stage;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [2047:0] l_re_in = '0;
    logic [2047:0] l_im_in = '0;
    logic [2047:0] inv_re, inv_im, tr_re, tr_im;
    logic          out_valid, busy, div_err;

    int total = 0;
    int bad   = 0;

    logic          armed    = 1'b0;
    logic          m_busy   = 1'b0;
    logic          chk_zero = 1'b0;
    int            m_cyc    = 0;
    logic [2047:0] e_re = '0, e_im = '0, e_tre = '0, e_tim = '0;
    logic          e_err = 1'b0;

    always #5 clk = ~clk;

    tri_inverse_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .L_real_in           (l_re_in),
        .L_imag_in           (l_im_in),
        .L_inv_real_out      (inv_re),
        .L_inv_imag_out      (inv_im),
        .L_inv_tran_real_out (tr_re),
        .L_inv_tran_imag_out (tr_im),
        .out_valid           (out_valid),
        .busy                (busy),
        .div_err             (div_err)
    );

    function automatic logic [31:0] elem(input logic [2047:0] v, input int r, input int c);
        return v[(r*8+c)*32 +: 32];
    endfunction

    function automatic logic [2047:0] put(input logic [2047:0] v, input int r, input int c,
                                          input logic [31:0] x);
        logic [2047:0] t;
        t = v;
        t[(r*8+c)*32 +: 32] = x;
        return t;
    endfunction

    function automatic logic [2047:0] diag_matrix(input logic [31:0] dv);
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t = put(t, i, i, dv);
        return t;
    endfunction

    // X = L^-1 by forward substitution in the fixed-point rules of the stage.
    task automatic build_model(input logic [2047:0] lr, input logic [2047:0] li);
        int     xr[64];
        int     xi[64];
        int     rc[8];
        longint d, ar, ai, br, bi, acc_r, acc_i;
        int     t_r, t_i;
        e_err = 1'b0;
        for (int e = 0; e < 64; e++) begin
            xr[e] = 0;
            xi[e] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            d = longint'($signed(elem(lr, i, i)));
            if (d <= longint'(2**27)) begin
                rc[i] = 32'h7FFF_FFFF;
                e_err = 1'b1;
            end else begin
                rc[i] = int'((64'sd1 <<< 58) / d);
            end
            xr[i*9] = rc[i];
        end
        for (int j = 0; j < 7; j++) begin
            for (int i = j + 1; i < 8; i++) begin
                acc_r = 0;
                acc_i = 0;
                for (int k = j; k < i; k++) begin
                    ar = longint'($signed(elem(lr, i, k)));
                    ai = longint'($signed(elem(li, i, k)));
                    br = longint'(xr[k*8+j]);
                    bi = longint'(xi[k*8+j]);
                    acc_r += (ar*br - ai*bi) >>> 29;
                    acc_i += (ar*bi + ai*br) >>> 29;
                end
                t_r = int'(acc_r);
                t_i = int'(acc_i);
                xr[i*8+j] = int'(-((longint'(t_r) * longint'(rc[i])) >>> 29));
                xi[i*8+j] = int'(-((longint'(t_i) * longint'(rc[i])) >>> 29));
            end
        end
        e_re = '0; e_im = '0; e_tre = '0; e_tim = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                e_re[(r*8+c)*32 +: 32]  = xr[r*8+c];
                e_im[(r*8+c)*32 +: 32]  = xi[r*8+c];
                e_tre[(c*8+r)*32 +: 32] = xr[r*8+c];
                e_tim[(c*8+r)*32 +: 32] = -xi[r*8+c];
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic checkVec(input string name, input logic [2047:0] got, input logic [2047:0] want);
        total++;
        if (got !== want) begin
            bad++;
            for (int e = 0; e < 64; e++) begin
                if (got[e*32 +: 32] !== want[e*32 +: 32]) begin
                    $display("[TB] FAIL %s elem(%0d,%0d) got=%h want=%h",
                             name, e/8, e%8, got[e*32 +: 32], want[e*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    // Run tracking: acceptance at cycle 0, out_valid presented for the edge of cycle 441.
    always @(posedge clk) begin
        if (rst) begin
            armed    = 1'b1;
            m_busy   = 1'b0;
            m_cyc    = 0;
            chk_zero = 1'b1;
        end else begin
            chk_zero = 1'b0;
            if (m_busy) begin
                m_cyc++;
                if (m_cyc == 441) m_busy = 1'b0;
            end else if (in_valid) begin
                m_busy = 1'b1;
                m_cyc  = 0;
                build_model(l_re_in, l_im_in);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_busy && m_cyc == 440});
            checkOutput("busy", {31'd0, busy}, {31'd0, m_busy});
            if (chk_zero) begin
                checkVec("rst_inv_re", inv_re, '0);
                checkVec("rst_inv_im", inv_im, '0);
                checkVec("rst_tr_re", tr_re, '0);
                checkVec("rst_tr_im", tr_im, '0);
                checkOutput("rst_div_err", {31'd0, div_err}, 32'd0);
            end
            if (m_busy && m_cyc == 440) begin
                checkVec("inv_re", inv_re, e_re);
                checkVec("inv_im", inv_im, e_im);
                checkVec("tr_re", tr_re, e_tre);
                checkVec("tr_im", tr_im, e_tim);
                checkOutput("div_err", {31'd0, div_err}, {31'd0, e_err});
            end
        end
    end

    // Pulse in_valid for one edge, then scramble the inputs to show they were latched.
    task automatic applyStimulus(input logic [2047:0] lr, input logic [2047:0] li);
        @(negedge clk);
        l_re_in  = lr;
        l_im_in  = li;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 0; e < 64; e++) begin
            l_re_in[e*32 +: 32] = $urandom();
            l_im_in[e*32 +: 32] = $urandom();
        end
    endtask

    task automatic waitDone(input string name);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL %s timeout got=no out_valid want=out_valid", name);
    endtask

    logic [2047:0] lr, li;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] identity");
        applyStimulus(diag_matrix(32'h2000_0000), '0);
        waitDone("t1");
        checkOutput("t1_model_x00", elem(e_re, 0, 0), 32'h2000_0000);
        checkOutput("t1_x00", elem(inv_re, 0, 0), 32'h2000_0000);
        checkOutput("t1_x77", elem(inv_re, 7, 7), 32'h2000_0000);
        checkOutput("t1_x10", elem(inv_re, 1, 0), 32'h0);
        checkOutput("t1_h33", elem(tr_re, 3, 3), 32'h2000_0000);
        checkOutput("t1_err", {31'd0, div_err}, 32'd0);

        $display("[TB] diagonal 2.0");
        applyStimulus(diag_matrix(32'h4000_0000), '0);
        waitDone("t2");
        checkOutput("t2_model_x55", elem(e_re, 5, 5), 32'h1000_0000);
        checkOutput("t2_x00", elem(inv_re, 0, 0), 32'h1000_0000);
        checkOutput("t2_x66", elem(inv_re, 6, 6), 32'h1000_0000);
        checkOutput("t2_x64", elem(inv_re, 6, 4), 32'h0);

        $display("[TB] single off-diagonal");
        lr = put(diag_matrix(32'h2000_0000), 1, 0, 32'h1000_0000);
        li = put('0, 1, 0, 32'h0800_0000);
        applyStimulus(lr, li);
        waitDone("t3");
        checkOutput("t3_model_x10_re", elem(e_re, 1, 0), 32'hF000_0000);
        checkOutput("t3_x10_re", elem(inv_re, 1, 0), 32'hF000_0000);
        checkOutput("t3_x10_im", elem(inv_im, 1, 0), 32'hF800_0000);
        checkOutput("t3_h01_re", elem(tr_re, 0, 1), 32'hF000_0000);
        checkOutput("t3_h01_im", elem(tr_im, 0, 1), 32'h0800_0000);
        checkOutput("t3_x20_re", elem(inv_re, 2, 0), 32'h0);
        checkOutput("t3_x20_im", elem(inv_im, 2, 0), 32'h0);

        $display("[TB] zero pivot");
        applyStimulus(put(diag_matrix(32'h2000_0000), 3, 3, 32'h0), '0);
        waitDone("t4");
        checkOutput("t4_err", {31'd0, div_err}, 32'd1);
        checkOutput("t4_x33", elem(inv_re, 3, 3), 32'h7FFF_FFFF);
        checkOutput("t4_x44", elem(inv_re, 4, 4), 32'h2000_0000);

        $display("[TB] pivot threshold");
        lr = put(diag_matrix(32'h2000_0000), 2, 2, 32'h0800_0001);
        lr = put(lr, 5, 5, 32'h0800_0000);
        applyStimulus(lr, '0);
        waitDone("t4b");
        checkOutput("t4b_model_x22", elem(e_re, 2, 2), 32'h7FFF_FFF0);
        checkOutput("t4b_x22", elem(inv_re, 2, 2), 32'h7FFF_FFF0);
        checkOutput("t4b_x55", elem(inv_re, 5, 5), 32'h7FFF_FFFF);
        checkOutput("t4b_err", {31'd0, div_err}, 32'd1);

        $display("[TB] dense matrix, ignored upper triangle");
        lr = '0;
        li = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == c) lr = put(lr, r, c, 32'h2000_0000 + $urandom_range(0, 32'h1FFF_FFFF));
                else        lr = put(lr, r, c, $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000);
                li = put(li, r, c, $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000);
            end
        end
        applyStimulus(lr, li);
        waitDone("t_dense");

        $display("[TB] start ignored while busy");
        applyStimulus(diag_matrix(32'h4000_0000), '0);
        repeat (99) @(negedge clk);
        l_re_in  = diag_matrix(32'h2000_0000);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waitDone("t5");
        checkOutput("t5_x11", elem(inv_re, 1, 1), 32'h1000_0000);
        repeat (5) @(negedge clk);

        $display("[TB] reset mid-run");
        applyStimulus(put(diag_matrix(32'h2000_0000), 4, 2, 32'h0400_0000), '0);
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (460) @(negedge clk);
        applyStimulus(put(diag_matrix(32'h2000_0000), 4, 2, 32'h0400_0000), '0);
        waitDone("t6");
        checkOutput("t6_x42", elem(inv_re, 4, 2), 32'hFC00_0000);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
